// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the display update scheduler.
// Holds the default VGA 640x480@60 timing constants, the scheduler FSM
// state encoding and the requester identifiers used by the arbiter.
package display_pkg;

  // Visible area defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Remaining horizontal timing (pixels)
  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT + H_SYNC + H_BACK;

  // Remaining vertical timing (lines)
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT + V_SYNC + V_BACK;

  // Scheduler FSM: shadow clean, shadow dirty, one-cycle copy to outputs
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } sched_state_t;

  // Requester identities for the round-robin arbiter
  typedef enum logic {
    REQ_ELEV = 1'b0,
    REQ_PPL  = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2 -- two-requester round-robin arbiter (elevator / people).
// Ports:
//   pixel_clk  : clock
//   reset_n    : synchronous active-low reset; last_grant returns to REQ_PPL
//   enable     : when low no grant is issued and last_grant holds
//   req_elev   : elevator request
//   req_ppl    : people request
//   grant_elev : one-cycle elevator grant (combinational)
//   grant_ppl  : one-cycle people grant (combinational)
module rr_arbiter2
  import display_pkg::*;
(
  input  logic pixel_clk,
  input  logic reset_n,
  input  logic enable,
  input  logic req_elev,
  input  logic req_ppl,
  output logic grant_elev,
  output logic grant_ppl
);

  req_id_t last_grant;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant_elev = 1'b0;
    grant_ppl  = 1'b0;
    if (enable) begin
      if (req_elev && req_ppl) begin
        if (last_grant == REQ_PPL) grant_elev = 1'b1;
        else                       grant_ppl  = 1'b1;
      end else begin
        grant_elev = req_elev;
        grant_ppl  = req_ppl;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n)        last_grant <= REQ_PPL;
    else if (grant_elev) last_grant <= REQ_ELEV;
    else if (grant_ppl)  last_grant <= REQ_PPL;
  end

endmodule

// File: rtl/display_update_scheduler.sv
// display_update_scheduler -- collects display writes from the elevator and
// people requesters into shadow registers and copies them to the committed
// display outputs only in the cycle after vblank-start, so a frame never
// shows a half-updated state.
//
// Configuration macro: PEOPLE_DATA_EN
//   defined   : people requester fully functional
//   undefined : ppl_req ignored, ppl_ack and people_data tied to 0
//
// Ports:
//   pixel_clk        : clock
//   reset_n          : synchronous active-low reset
//   horiz_count      : [9:0] horizontal position from the VGA timing generator
//   vert_count       : [9:0] vertical position from the VGA timing generator
//   elev_req         : elevator write request, held until elev_ack
//   elev_destination : [7:0] elevator destination write data
//   elev_sim_state   : [1:0] elevator simulation state write data
//   elev_ack         : one-cycle elevator acknowledge, data sampled this cycle
//   ppl_req          : people write request, held until ppl_ack
//   ppl_data         : [25:0] people write data
//   ppl_ack          : one-cycle people acknowledge, data sampled this cycle
//   destination      : [7:0] committed destination
//   sim_state        : [1:0] committed simulation state
//   people_data      : [25:0] committed people data
//   commit_pulse     : high for the single COMMIT cycle
//   update_pending   : shadow holds uncommitted data (state != IDLE)
//   frame_count      : [7:0] vblank-start counter, wraps 255 -> 0
module display_update_scheduler
  import display_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [9:0]  horiz_count,
  input  logic [9:0]  vert_count,
  input  logic        elev_req,
  input  logic [7:0]  elev_destination,
  input  logic [1:0]  elev_sim_state,
  output logic        elev_ack,
  input  logic        ppl_req,
  input  logic [25:0] ppl_data,
  output logic        ppl_ack,
  output logic [7:0]  destination,
  output logic [1:0]  sim_state,
  output logic [25:0] people_data,
  output logic        commit_pulse,
  output logic        update_pending,
  output logic [7:0]  frame_count
);

  localparam logic [9:0] V_START = 10'(V_ACTIVE);

  sched_state_t state, state_next;
  logic vblank_start;
  logic ack_enable;
  logic ppl_req_gated;
  logic grant_elev, grant_ppl;
  logic any_ack;

  logic [7:0] shadow_dest, shadow_dest_n;
  logic [1:0] shadow_sim,  shadow_sim_n;

  // The commit point depends only on the line count; the visible width
  // does not influence scheduling.
  logic unused_cfg;
  assign unused_cfg = H_ACTIVE[0];

  assign vblank_start = (vert_count == V_START) && (horiz_count == '0);

`ifdef PEOPLE_DATA_EN
  assign ppl_req_gated = ppl_req;
`else
  assign ppl_req_gated = 1'b0;
  logic unused_ppl;
  assign unused_ppl = ^{ppl_req, ppl_data};
`endif

  rr_arbiter2 u_arb (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .enable     (ack_enable),
    .req_elev   (elev_req),
    .req_ppl    (ppl_req_gated),
    .grant_elev (grant_elev),
    .grant_ppl  (grant_ppl)
  );

  assign elev_ack = grant_elev;
  assign any_ack  = grant_elev | grant_ppl;

  // FSM state register
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FSM next state. An ack landing in the vblank-start cycle from IDLE goes
  // straight to COMMIT so that write still makes this frame's commit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_ack) state_next = vblank_start ? ST_COMMIT : ST_PENDING;
      end
      ST_PENDING: begin
        if (vblank_start) state_next = ST_COMMIT;
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // FSM outputs. Acks are blocked in COMMIT and while reset is asserted.
  always_comb begin
    ack_enable     = reset_n && (state != ST_COMMIT);
    commit_pulse   = (state == ST_COMMIT);
    update_pending = (state != ST_IDLE);
  end

  // Shadow next value: lets a write acked in the vblank-start cycle be
  // copied to the outputs on the same edge that enters COMMIT.
  always_comb begin
    shadow_dest_n = shadow_dest;
    shadow_sim_n  = shadow_sim;
    if (grant_elev) begin
      shadow_dest_n = elev_destination;
      shadow_sim_n  = elev_sim_state;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      shadow_dest <= '0;
      shadow_sim  <= '0;
    end else begin
      shadow_dest <= shadow_dest_n;
      shadow_sim  <= shadow_sim_n;
    end
  end

  // Committed outputs load on entry to COMMIT, visible during COMMIT.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      destination <= '0;
      sim_state   <= '0;
    end else if (state_next == ST_COMMIT) begin
      destination <= shadow_dest_n;
      sim_state   <= shadow_sim_n;
    end
  end

`ifdef PEOPLE_DATA_EN
  logic [25:0] shadow_ppl, shadow_ppl_n;

  assign ppl_ack = grant_ppl;

  always_comb begin
    shadow_ppl_n = shadow_ppl;
    if (grant_ppl) shadow_ppl_n = ppl_data;
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) shadow_ppl <= '0;
    else          shadow_ppl <= shadow_ppl_n;
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n)                     people_data <= '0;
    else if (state_next == ST_COMMIT) people_data <= shadow_ppl_n;
  end
`else
  assign ppl_ack     = 1'b0;
  assign people_data = '0;
`endif

  always_ff @(posedge pixel_clk) begin
    if (!reset_n)          frame_count <= '0;
    else if (vblank_start) frame_count <= frame_count + 8'd1;
  end

endmodule

// File: tb/tb_display_update_scheduler.sv
// tb_display_update_scheduler -- directed bench for display_update_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_display_update_scheduler;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  horiz_count, vert_count;
  logic        elev_req;
  logic [7:0]  elev_destination;
  logic [1:0]  elev_sim_state;
  logic        elev_ack;
  logic        ppl_req;
  logic [25:0] ppl_data;
  logic        ppl_ack;
  logic [7:0]  destination;
  logic [1:0]  sim_state;
  logic [25:0] people_data;
  logic        commit_pulse, update_pending;
  logic [7:0]  frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_fc = 8'd0;

  always #5 pixel_clk = ~pixel_clk;

  display_update_scheduler dut (
    .pixel_clk        (pixel_clk),
    .reset_n          (reset_n),
    .horiz_count      (horiz_count),
    .vert_count       (vert_count),
    .elev_req         (elev_req),
    .elev_destination (elev_destination),
    .elev_sim_state   (elev_sim_state),
    .elev_ack         (elev_ack),
    .ppl_req          (ppl_req),
    .ppl_data         (ppl_data),
    .ppl_ack          (ppl_ack),
    .destination      (destination),
    .sim_state        (sim_state),
    .people_data      (people_data),
    .commit_pulse     (commit_pulse),
    .update_pending   (update_pending),
    .frame_count      (frame_count)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic set_pos(input int v, input int h);
    vert_count  = 10'(v);
    horiz_count = 10'(h);
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    elev_req = 1'b0;
    ppl_req  = 1'b0;
    set_pos(0, 0);
    tick();
    tick();
    reset_n = 1'b1;
    exp_fc  = 8'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    elev_req = 1'b1;
    ppl_req  = 1'b1;
    elev_destination = 8'hAA;
    ppl_data = 26'h3FFFFFF;
    set_pos(480, 0);
    tick();
    tick();
    n_checks++; if (destination !== 8'h00) begin n_fail++; $display("FAIL reset_dest: got %h expected 00", destination); end
    n_checks++; if (sim_state !== 2'b00) begin n_fail++; $display("FAIL reset_sim: got %b expected 00", sim_state); end
    n_checks++; if (people_data !== 26'h0) begin n_fail++; $display("FAIL reset_people: got %h expected 0", people_data); end
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_commit: got %b expected 0", commit_pulse); end
    n_checks++; if (update_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b expected 0", update_pending); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
    n_checks++; if (elev_ack !== 1'b0) begin n_fail++; $display("FAIL reset_elev_ack: got %b expected 0", elev_ack); end
    n_checks++; if (ppl_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ppl_ack: got %b expected 0", ppl_ack); end
    elev_req = 1'b0;
    ppl_req  = 1'b0;
    set_pos(0, 0);
    reset_n = 1'b1;
    exp_fc  = 8'd0;
  endtask

  task automatic test_basic_commit();
    set_pos(100, 0);
    elev_destination = 8'h05;
    elev_sim_state   = 2'b01;
    elev_req = 1'b1;
    #1;
    n_checks++; if (elev_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b expected 1", elev_ack); end
    tick();
    elev_req = 1'b0;
    #1;
    n_checks++; if (elev_ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_once: got %b expected 0", elev_ack); end
    n_checks++; if (update_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending: got %b expected 1", update_pending); end
    n_checks++; if (destination !== 8'h00) begin n_fail++; $display("FAIL basic_dest_hold: got %h expected 00", destination); end
    set_pos(480, 0);
    #1;
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_early_commit: got %b expected 0", commit_pulse); end
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(480, 1);
    n_checks++; if (destination !== 8'h05) begin n_fail++; $display("FAIL basic_dest: got %h expected 05", destination); end
    n_checks++; if (sim_state !== 2'b01) begin n_fail++; $display("FAIL basic_sim: got %b expected 01", sim_state); end
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL basic_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL basic_fc: got %0d expected %0d", frame_count, exp_fc); end
    tick();
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL basic_commit_1cyc: got %b expected 0", commit_pulse); end
    n_checks++; if (update_pending !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", update_pending); end
    n_checks++; if (destination !== 8'h05) begin n_fail++; $display("FAIL basic_dest_keep: got %h expected 05", destination); end
  endtask

  task automatic test_round_robin();
    logic exp_e, exp_p;
    logic [25:0] exp_people;
    do_reset();
    set_pos(10, 5);
    elev_destination = 8'h11;
    elev_sim_state   = 2'b10;
    ppl_data = 26'h2ABCDEF;
    elev_req = 1'b1;
    ppl_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef PEOPLE_DATA_EN
      exp_e = (i % 2 == 0);
      exp_p = (i % 2 == 1);
`else
      exp_e = 1'b1;
      exp_p = 1'b0;
`endif
      n_checks++; if (elev_ack !== exp_e) begin n_fail++; $display("FAIL rr_elev_ack[%0d]: got %b expected %b", i, elev_ack, exp_e); end
      n_checks++; if (ppl_ack !== exp_p) begin n_fail++; $display("FAIL rr_ppl_ack[%0d]: got %b expected %b", i, ppl_ack, exp_p); end
      n_checks++; if (elev_ack && ppl_ack) begin n_fail++; $display("FAIL rr_both[%0d]: got both acks expected one", i); end
      tick();
    end
    elev_req = 1'b0;
    ppl_req  = 1'b0;
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(480, 1);
`ifdef PEOPLE_DATA_EN
    exp_people = 26'h2ABCDEF;
`else
    exp_people = 26'h0;
`endif
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL rr_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (destination !== 8'h11) begin n_fail++; $display("FAIL rr_dest: got %h expected 11", destination); end
    n_checks++; if (sim_state !== 2'b10) begin n_fail++; $display("FAIL rr_sim: got %b expected 10", sim_state); end
    n_checks++; if (people_data !== exp_people) begin n_fail++; $display("FAIL rr_people: got %h expected %h", people_data, exp_people); end
    tick();
  endtask

  task automatic test_last_write_wins();
    set_pos(50, 0);
    elev_sim_state = 2'b00;
    elev_destination = 8'h03;
    elev_req = 1'b1;
    tick();
    elev_req = 1'b0;
    tick();
    elev_destination = 8'h07;
    elev_req = 1'b1;
    tick();
    elev_req = 1'b0;
    tick();
    n_checks++; if (destination !== 8'h11) begin n_fail++; $display("FAIL lww_tear_free: got %h expected 11", destination); end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(480, 1);
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL lww_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (destination !== 8'h07) begin n_fail++; $display("FAIL lww_dest: got %h expected 07", destination); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL lww_single_commit[%0d]: got %b expected 0", i, commit_pulse); end
    end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(0, 0);
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL idle_vblank_commit: got %b expected 0", commit_pulse); end
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL idle_vblank_fc: got %0d expected %0d", frame_count, exp_fc); end
  endtask

  task automatic test_vblank_edge();
    set_pos(480, 0);
    elev_destination = 8'h0A;
    elev_sim_state   = 2'b10;
    elev_req = 1'b1;
    #1;
    n_checks++; if (elev_ack !== 1'b1) begin n_fail++; $display("FAIL edge_ack_vblank: got %b expected 1", elev_ack); end
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(480, 1);
    elev_destination = 8'h0B;
    elev_sim_state   = 2'b11;
    #1;
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL edge_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (destination !== 8'h0A) begin n_fail++; $display("FAIL edge_dest: got %h expected 0a", destination); end
    n_checks++; if (sim_state !== 2'b10) begin n_fail++; $display("FAIL edge_sim: got %b expected 10", sim_state); end
    n_checks++; if (elev_ack !== 1'b0) begin n_fail++; $display("FAIL edge_no_ack_in_commit: got %b expected 0", elev_ack); end
    tick();
    n_checks++; if (elev_ack !== 1'b1) begin n_fail++; $display("FAIL edge_ack_after_commit: got %b expected 1", elev_ack); end
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL edge_commit_end: got %b expected 0", commit_pulse); end
    tick();
    elev_req = 1'b0;
    n_checks++; if (update_pending !== 1'b1) begin n_fail++; $display("FAIL edge_pending: got %b expected 1", update_pending); end
    n_checks++; if (destination !== 8'h0A) begin n_fail++; $display("FAIL edge_dest_hold: got %h expected 0a", destination); end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(0, 0);
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL edge_next_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (destination !== 8'h0B) begin n_fail++; $display("FAIL edge_next_dest: got %h expected 0b", destination); end
    n_checks++; if (sim_state !== 2'b11) begin n_fail++; $display("FAIL edge_next_sim: got %b expected 11", sim_state); end
    tick();
  endtask

  task automatic test_frame_wrap();
    set_pos(0, 0);
    while (exp_fc != 8'd255) begin
      set_pos(480, 0);
      tick();
      exp_fc = exp_fc + 8'd1;
      set_pos(0, 0);
      tick();
    end
    n_checks++; if (frame_count !== 8'd255) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 255", frame_count); end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(0, 0);
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", frame_count); end
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL wrap_idle_commit: got %b expected 0", commit_pulse); end
    tick();
  endtask

  task automatic test_reset_pending();
    set_pos(200, 0);
    elev_destination = 8'h55;
    elev_sim_state   = 2'b11;
    elev_req = 1'b1;
    tick();
    elev_req = 1'b0;
    n_checks++; if (update_pending !== 1'b1) begin n_fail++; $display("FAIL rstp_pending: got %b expected 1", update_pending); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (update_pending !== 1'b0) begin n_fail++; $display("FAIL rstp_cleared: got %b expected 0", update_pending); end
    n_checks++; if (destination !== 8'h00) begin n_fail++; $display("FAIL rstp_dest: got %h expected 00", destination); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rstp_fc: got %0d expected 0", frame_count); end
    reset_n = 1'b1;
    exp_fc  = 8'd0;
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(480, 1);
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL rstp_no_commit: got %b expected 0", commit_pulse); end
    n_checks++; if (destination !== 8'h00) begin n_fail++; $display("FAIL rstp_dest_after: got %h expected 00", destination); end
    n_checks++; if (sim_state !== 2'b00) begin n_fail++; $display("FAIL rstp_sim_after: got %b expected 00", sim_state); end
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL rstp_fc_after: got %0d expected %0d", frame_count, exp_fc); end
    tick();
  endtask

  task automatic test_people();
    set_pos(300, 0);
    elev_req = 1'b0;
    ppl_data = 26'h1555555;
    ppl_req  = 1'b1;
`ifdef PEOPLE_DATA_EN
    #1;
    n_checks++; if (ppl_ack !== 1'b1) begin n_fail++; $display("FAIL ppl_ack: got %b expected 1", ppl_ack); end
    tick();
    ppl_req = 1'b0;
    n_checks++; if (update_pending !== 1'b1) begin n_fail++; $display("FAIL ppl_pending: got %b expected 1", update_pending); end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(0, 0);
    n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL ppl_commit: got %b expected 1", commit_pulse); end
    n_checks++; if (people_data !== 26'h1555555) begin n_fail++; $display("FAIL ppl_data: got %h expected 1555555", people_data); end
`else
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ppl_ack !== 1'b0) begin n_fail++; $display("FAIL ppl_off_ack[%0d]: got %b expected 0", i, ppl_ack); end
      tick();
      n_checks++; if (update_pending !== 1'b0) begin n_fail++; $display("FAIL ppl_off_pending[%0d]: got %b expected 0", i, update_pending); end
      n_checks++; if (people_data !== 26'h0) begin n_fail++; $display("FAIL ppl_off_data[%0d]: got %h expected 0", i, people_data); end
    end
    set_pos(480, 0);
    tick();
    exp_fc = exp_fc + 8'd1;
    set_pos(0, 0);
    n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL ppl_off_commit: got %b expected 0", commit_pulse); end
    n_checks++; if (people_data !== 26'h0) begin n_fail++; $display("FAIL ppl_off_data_vblank: got %h expected 0", people_data); end
    ppl_req = 1'b0;
`endif
    n_checks++; if (frame_count !== exp_fc) begin n_fail++; $display("FAIL ppl_fc: got %0d expected %0d", frame_count, exp_fc); end
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    elev_req = 1'b0;
    ppl_req = 1'b0;
    elev_destination = 8'h00;
    elev_sim_state = 2'b00;
    ppl_data = 26'h0;
    set_pos(0, 0);
    #1;
    test_reset();
    test_basic_commit();
    test_round_robin();
    test_last_write_wins();
    test_vblank_edge();
    test_frame_wrap();
    test_reset_pending();
    test_people();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_update_scheduler.md
DISPLAY_UPDATE_SCHEDULER -- requirements
Module: display_update_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame; the vblank-start point is vert_count == V_ACTIVE with horiz_count == 0.
REQ-003 SHALL have port pixel_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have ports horiz_count and vert_count, input, 10 bits each: position from the VGA timing generator.
REQ-006 SHALL have port elev_req, input, 1 bit; elev_destination, input, 8 bits; elev_sim_state, input, 2 bits; elev_ack, output, 1 bit.
REQ-007 SHALL have port ppl_req, input, 1 bit; ppl_data, input, 26 bits; ppl_ack, output, 1 bit.
REQ-008 SHALL have port destination, output, 8 bits; sim_state, output, 2 bits; people_data, output, 26 bits. These are the committed display values.
REQ-009 SHALL have port commit_pulse, output, 1 bit; update_pending, output, 1 bit; frame_count, output, 8 bits.

Function
REQ-010 Requester handshake: req is held until ack; ack is a 1-cycle pulse; data is sampled into the shadow registers on the ack cycle. A requester that keeps req high after ack issues a new request.
REQ-011 At most one ack SHALL be issued per cycle; the elevator write updates shadow destination and sim_state together.
REQ-012 Simultaneous requests: round-robin. The requester not granted last wins. last_grant updates only on an ack.
REQ-013 FSM states: IDLE (shadow clean), PENDING (shadow dirty), COMMIT (one cycle).
- IDLE to PENDING on any ack.
- PENDING to COMMIT in the cycle after vblank-start.
- COMMIT to IDLE unconditionally.
REQ-014 In the vblank-start cycle, acks SHALL still be granted; such a write is included in the following commit.
REQ-015 In COMMIT: copy the shadow to the outputs, assert commit_pulse for exactly 1 cycle, and issue no ack. A request pending during COMMIT is acked no earlier than the next cycle.
REQ-016 A vblank-start in IDLE SHALL produce no commit and no commit_pulse.
REQ-017 Multiple writes within one frame: last write wins; a single commit per frame.
REQ-018 update_pending = (state != IDLE).
REQ-019 frame_count SHALL increment on every vblank-start and wrap 255 to 0.
REQ-020 Outputs change only in COMMIT (tear-free); latency from ack to output is vblank-start + 1 cycle.

Reset
REQ-021 With reset_n low at a pixel_clk edge:
- state = IDLE; all shadow and output registers = 0; commit_pulse = 0; acks = 0; frame_count = 0.
- last_grant = ppl, so the elevator wins the first tie.
REQ-022 Reset mid-frame or mid-COMMIT SHALL discard pending shadow data with no partial commit.

Configuration
REQ-023 Macro PEOPLE_DATA_EN defined: the people requester is fully functional.
REQ-024 PEOPLE_DATA_EN undefined:
- ppl_req is ignored; ppl_ack is constant 0; people_data is constant 0.
- The arbiter always grants the elevator; all other behaviour is unchanged.

Structure
REQ-025 Package display_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the remaining VGA timing constants, the FSM state enum, and the requester-id enum.
REQ-026 Sub-module rr_arbiter2 SHALL provide the two-requester round-robin grant with a last_grant register.

Verification
REQ-027 Reset then elev_req with elev_destination=8'h05, elev_sim_state=2'b01 at vert=100:
- elev_ack pulses once; update_pending = 1; destination stays 0.
- At vert=480, horiz=0 plus 1 cycle: destination=8'h05, sim_state=2'b01, commit_pulse=1 for 1 cycle.
REQ-028 elev_req and ppl_req asserted together from reset:
- Acks in order elev, ppl, elev, ppl; never both in one cycle.
REQ-029 Two elevator writes (8'h03 then 8'h07) in one frame: a single commit with destination=8'h07.
REQ-030 Write acked exactly in the vblank-start cycle: committed the next cycle. A request raised during COMMIT: acked the cycle after COMMIT and committed next frame.
REQ-031 frame_count=255 then vblank-start: frame_count=0. An IDLE vblank-start gives commit_pulse=0.
REQ-032 reset_n low during PENDING: no commit at the next vblank and outputs remain 0. Without PEOPLE_DATA_EN, ppl_req=1 gives ppl_ack=0 and people_data=0 throughout.
